// File: rtl/fa_step3.sv
// fa_step3 - final stage of the floating-point adder pipeline.
//
// Takes the partial Kogge-Stone prefix terms left by the level-2 stage,
// finishes the carry tree (spans 8/16/32), merges the carry-in, forms the
// mantissa sum, then normalizes and packs an IEEE-754 single result.
// Two register stages, no stall; rounding is truncation.
//
// Ports:
//   CLK, RESETn      clock (rising edge), async active-low reset
//   in_valid         qualifies the inputs of this cycle
//   in_sign, in_ex   result sign and common biased exponent
//   in_yn            effective subtraction; operand 2 is already
//                    ones-complemented upstream, carry-in 1 is injected here
//   in_P0            bitwise propagate, bit k = mantissa bit k-1, bit 0 = 0
//   in_P2, in_G2     span-4 group propagate/generate
//   in_GG            complete generate prefixes, bits 3..0
//   out_valid        in_valid delayed two cycles
//   out_result       {sign, exponent, fraction}
//   out_zero/ovf/unf exact cancellation / saturated to inf / flushed to +0
module fa_step3 #(
  parameter int MW = 24
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          in_valid,
  input  logic          in_sign,
  input  logic          in_yn,
  input  logic [7:0]    in_ex,
  input  logic [MW:0]   in_P0,
  input  logic [MW:0]   in_P2,
  input  logic [MW:0]   in_G2,
  input  logic [MW:0]   in_GG,
  output logic          out_valid,
  output logic [31:0]   out_result,
  output logic          out_zero,
  output logic          out_ovf,
  output logic          out_unf
);

  localparam int STAGES = 2;

  // vld_pipe[0] is the live input; [STAGES] drives out_valid.
  logic [STAGES:0] vld_pipe;

  // ---------------- Stage A: carry tree and sum ----------------
  logic [MW:0] g3, p3, g4, p4, gf, pg, c, s;
  logic [MW:0] m_d;

  always_comb begin
    // span 8: bits 4..7 can already reach the complete prefixes in GG
    g3 = in_G2;
    p3 = in_P2;
    for (int j = 0; j < 4; j++) g3[j] = in_GG[j];
    for (int j = 4; j <= MW; j++) begin
      if (j >= 8) begin
        g3[j] = in_G2[j] | (in_P2[j] & in_G2[j-4]);
        p3[j] = in_P2[j] & in_P2[j-4];
      end else begin
        g3[j] = in_G2[j] | (in_P2[j] & in_GG[j-4]);
      end
    end
    // span 16: bits 0..7 are complete after span 8
    g4 = g3;
    p4 = p3;
    for (int j = 8; j <= MW; j++) begin
      g4[j] = g3[j] | (p3[j] & g3[j-8]);
      if (j >= 16) p4[j] = p3[j] & p3[j-8];
    end
    // span 32: bits 0..15 are complete after span 16
    gf = g4;
    for (int j = 16; j <= MW; j++) gf[j] = g4[j] | (p4[j] & g4[j-16]);

    // Propagate over k..1 only: bit 0 carries P0=0, so the tree's group
    // propagate cannot be reused for the carry-in merge.
    pg    = '0;
    pg[0] = 1'b1;
    for (int k = 1; k <= MW; k++) pg[k] = pg[k-1] & in_P0[k];

    c    = '0;
    c[0] = in_yn;
    for (int k = 1; k <= MW; k++) c[k] = gf[k] | (pg[k] & in_yn);

    s = '0;
    for (int k = 1; k <= MW; k++) s[k] = in_P0[k] ^ c[k-1];

    // carry-out of a subtraction is the end-around artefact, drop it
    m_d = {c[MW] & ~in_yn, s[MW:1]};
  end

  logic [MW:0] m_q;
  logic [7:0]  ex_q;
  logic        sign_q;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      m_q    <= '0;
      ex_q   <= '0;
      sign_q <= 1'b0;
    end else begin
      m_q    <= m_d;
      ex_q   <= in_ex;
      sign_q <= in_sign;
    end
  end

  // ---------------- Stage B: normalize and pack ----------------
  logic [4:0]    lz;
  logic          found;
  logic [8:0]    e_inc;
  logic [MW-1:0] shifted;
  logic [31:0]   res_d;
  logic          zero_d, ovf_d, unf_d;

  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!found && m_q[i]) begin
        lz    = 5'(MW - 1 - i);
        found = 1'b1;
      end
    end
    e_inc   = {1'b0, ex_q} + 9'd1;
    shifted = m_q[MW-1:0] << lz;

    res_d  = '0;
    zero_d = 1'b0;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    if (m_q[MW]) begin
      if (e_inc >= 9'd255) begin
        res_d = {sign_q, 8'hFF, 23'd0};
        ovf_d = 1'b1;
      end else begin
        res_d = {sign_q, e_inc[7:0], m_q[MW-1:1]};
      end
    end else if (m_q == '0) begin
      zero_d = 1'b1;                  // +0 regardless of sign
    end else if (ex_q > {3'd0, lz}) begin
      res_d = {sign_q, ex_q - {3'd0, lz}, shifted[MW-2:0]};
    end else begin
      unf_d = 1'b1;                   // no denormals: flush to +0
    end
  end

  assign vld_pipe[0] = in_valid;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      vld_pipe[STAGES:1] <= '0;
      out_result         <= '0;
      out_zero           <= 1'b0;
      out_ovf            <= 1'b0;
      out_unf            <= 1'b0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      out_result         <= res_d;
      out_zero           <= zero_d;
      out_ovf            <= ovf_d;
      out_unf            <= unf_d;
    end
  end

  assign out_valid = vld_pipe[STAGES];

  // Inputs bits the tree never needs (already complete or fixed to 0).
  logic unused_bits;
  assign unused_bits = ^{in_P0[0], in_GG[MW:4], shifted[MW-1]};

endmodule

// File: tb/tb_fa_step3.sv
// Directed and streamed checks for fa_step3. Upstream prefix terms are
// built from raw operands; expected results come from an arithmetic
// truncating-adder model.
module tb_fa_step3;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        in_valid, in_sign, in_yn;
  logic [7:0]  in_ex;
  logic [24:0] in_P0, in_P2, in_G2, in_GG;
  logic        out_valid, out_zero, out_ovf, out_unf;
  logic [31:0] out_result;

  int n_tests = 0;
  int n_fail  = 0;

  fa_step3 #(.MW(24)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .in_valid(in_valid), .in_sign(in_sign), .in_yn(in_yn), .in_ex(in_ex),
    .in_P0(in_P0), .in_P2(in_P2), .in_G2(in_G2), .in_GG(in_GG),
    .out_valid(out_valid), .out_result(out_result),
    .out_zero(out_zero), .out_ovf(out_ovf), .out_unf(out_unf)
  );

  always #5 CLK = ~CLK;

  // Upstream model: bitwise P/G, then span-4 groups by plain ripple.
  task automatic drive(input logic [23:0] a, input logic [23:0] b,
                       input logic yn, input logic sign,
                       input logic [7:0] ex, input logic v);
    logic [24:0] p0, g0, p2, g2, gg;
    logic gacc, pacc;
    p0 = '0; g0 = '0; p2 = '0; g2 = '0; gg = '0;
    for (int k = 1; k <= 24; k++) begin
      p0[k] = a[k-1] ^ b[k-1];
      g0[k] = a[k-1] & b[k-1];
    end
    for (int j = 0; j <= 24; j++) begin
      gacc = 1'b0;
      pacc = 1'b1;
      for (int i = ((j > 3) ? j - 3 : 0); i <= j; i++) begin
        gacc = g0[i] | (p0[i] & gacc);
        pacc = pacc & p0[i];
      end
      p2[j] = pacc;
      g2[j] = gacc;
      if (j < 4) gg[j] = gacc;
    end
    in_P0 = p0; in_P2 = p2; in_G2 = g2; in_GG = gg;
    in_yn = yn; in_sign = sign; in_ex = ex; in_valid = v;
  endtask

  // Returns {zero, ovf, unf, result}.
  function automatic logic [34:0] model(input logic [23:0] a,
                                        input logic [23:0] b,
                                        input logic yn, input logic sign,
                                        input logic [7:0] ex);
    logic [24:0] sum, m;
    logic [8:0]  e9;
    logic [23:0] sh;
    int lz;
    sum = {1'b0, a} + {1'b0, b} + {24'd0, yn};
    m   = {sum[24] & ~yn, sum[23:0]};
    e9  = {1'b0, ex} + 9'd1;
    if (m[24]) begin
      if (e9 >= 9'd255) return {3'b010, sign, 8'hFF, 23'd0};
      return {3'b000, sign, e9[7:0], m[23:1]};
    end
    if (m == '0) return {3'b100, 32'd0};
    lz = 0;
    while (!m[23-lz]) lz++;
    if (int'(ex) > lz) begin
      sh = m[23:0] << lz;
      return {3'b000, sign, 8'(int'(ex) - lz), sh[22:0]};
    end
    return {3'b001, 32'd0};
  endfunction

  task automatic test_reset;
    RESETn = 1'b0;
    drive(24'd0, 24'd0, 1'b0, 1'b0, 8'd0, 1'b0);
    #12;
    n_tests++;
    if ({out_valid, out_zero, out_ovf, out_unf, out_result} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want 0",
               {out_valid, out_zero, out_ovf, out_unf, out_result});
    end
    @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL first_valid: got %b want 0", out_valid);
    end
  endtask

  // One directed operation with hand-computed expectation {v,z,o,u,res}.
  task automatic test_directed(input string name, input logic [23:0] a,
                               input logic [23:0] b, input logic yn,
                               input logic sign, input logic [7:0] ex,
                               input logic [35:0] expv);
    logic [35:0] got;
    @(negedge CLK);
    drive(a, b, yn, sign, ex, 1'b1);
    @(negedge CLK);
    drive(24'd0, 24'd0, 1'b0, 1'b0, 8'd0, 1'b0);
    @(negedge CLK);
    got = {out_valid, out_zero, out_ovf, out_unf, out_result};
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, expv);
    end
    @(negedge CLK);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_valid_drop: got %b want 0", name, out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [35:0] expq[$];
    logic [35:0] got, want;
    logic [23:0] a, b, bo;
    logic        yn, sign, v;
    logic [7:0]  ex;
    int          mode;
    for (int cyc = 0; cyc < 1002; cyc++) begin
      @(negedge CLK);
      if (cyc >= 2) begin
        want = expq.pop_front();
        got  = {out_valid, out_zero, out_ovf, out_unf, out_result};
        n_tests++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL stream[%0d]: got %h want %h", cyc - 2, got, want);
        end
      end
      if (cyc < 1000) begin
        mode = int'($urandom_range(0, 3));
        yn   = (mode >= 2);
        sign = 1'($urandom);
        v    = ($urandom_range(0, 4) != 0);
        a    = {1'b1, 23'($urandom)};
        if (!yn) begin
          b = 24'($urandom) >> $urandom_range(0, 8);
        end else begin
          if (mode == 3) bo = a - 24'($urandom_range(0, 15));
          else           bo = 24'($urandom) & a;   // subset keeps bo <= a
          b = ~bo;
        end
        ex = 8'($urandom_range(1, 254));
        if ($urandom_range(0, 7) == 0)
          ex = $urandom_range(0, 1) ? 8'd254 : 8'($urandom_range(1, 20));
        drive(a, b, yn, sign, ex, v);
        expq.push_back({v, model(a, b, yn, sign, ex)});
      end else begin
        drive(24'd0, 24'd0, 1'b0, 1'b0, 8'd0, 1'b0);
      end
    end
  endtask

  task automatic test_reset_mid;
    @(negedge CLK);
    drive(24'h800000, 24'h800000, 1'b0, 1'b0, 8'd127, 1'b1);
    @(negedge CLK);
    drive(24'hC00000, 24'h7FFFFF, 1'b1, 1'b0, 8'd127, 1'b1);
    @(posedge CLK);
    #2;
    RESETn = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, out_zero, out_ovf, out_unf, out_result} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got %h want 0",
               {out_valid, out_zero, out_ovf, out_unf, out_result});
    end
    @(negedge CLK);
    drive(24'd0, 24'd0, 1'b0, 1'b0, 8'd0, 1'b0);
    RESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_tests++;
      if (out_valid !== 1'b0 || out_result !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_mid_stale[%0d]: valid %b result %h want 0 0",
                 i, out_valid, out_result);
      end
    end
  endtask

  initial begin
    test_reset();
    //                        a          b        yn    sign  ex      {v,z,o,u,result}
    test_directed("add_1p1", 24'h800000, 24'h800000, 1'b0, 1'b0, 8'd127, {4'b1000, 32'h40000000});
    test_directed("sub_1p5", 24'hC00000, 24'h7FFFFF, 1'b1, 1'b0, 8'd127, {4'b1000, 32'h3F000000});
    test_directed("cancel",  24'h800000, 24'h7FFFFF, 1'b1, 1'b1, 8'd127, {4'b1100, 32'h00000000});
    test_directed("ovf",     24'h800000, 24'h800000, 1'b0, 1'b1, 8'd254, {4'b1010, 32'hFF800000});
    test_directed("unf",     24'hC00000, 24'h7FFFFF, 1'b1, 1'b0, 8'd1,   {4'b1001, 32'h00000000});
    // 1.5 + 1.25 = 2.75 -> 0x40300000 (no carry-in, carry out kept)
    test_directed("add_frac", 24'hC00000, 24'hA00000, 1'b0, 1'b0, 8'd127, {4'b1000, 32'h40300000});
    // ex=253 with carry: 254 is still finite -> 0x7F000000
    test_directed("ovf_edge", 24'h800000, 24'h800000, 1'b0, 1'b0, 8'd253, {4'b1000, 32'h7F000000});
    // 1.0 - (1.0 - 2^-23): M = 1, lz = 23, ex 24 > 23 -> exponent 1, fraction 0
    test_directed("unf_edge", 24'h800000, 24'h800000, 1'b1, 1'b1, 8'd24,  {4'b1000, 32'h80800000});
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
